// File: rtl/rtc_bus_transaction_driver_if.sv
// Command handshake and multiplexed A/D bus signals of the RTC bus transaction driver.
// master: the driver itself; slave: the control FSM / pad side that feeds it and observes it.
interface rtc_bus_transaction_driver_if;
    logic       in_en_funcion_rtc;
    logic       in_funcion_w_r;
    logic       in_flag_inicio;
    logic [7:0] in_addr_ram_rtc;
    logic [7:0] in_dato_inicio;
    logic [7:0] in_dato_usuario;
    logic [7:0] in_bus_dato;
    logic [7:0] out_bus_dato;
    logic       out_bus_oe;
    logic       out_cs_n;
    logic       out_rd_n;
    logic       out_wr_n;
    logic       out_ad;
    logic       out_flag_done;
    logic [7:0] out_dato_leido;
    logic       out_dato_valido;
    logic       out_busy;

    modport master (
        input  in_en_funcion_rtc, in_funcion_w_r, in_flag_inicio, in_addr_ram_rtc,
               in_dato_inicio, in_dato_usuario, in_bus_dato,
        output out_bus_dato, out_bus_oe, out_cs_n, out_rd_n, out_wr_n, out_ad,
               out_flag_done, out_dato_leido, out_dato_valido, out_busy
    );

    modport slave (
        output in_en_funcion_rtc, in_funcion_w_r, in_flag_inicio, in_addr_ram_rtc,
               in_dato_inicio, in_dato_usuario, in_bus_dato,
        input  out_bus_dato, out_bus_oe, out_cs_n, out_rd_n, out_wr_n, out_ad,
               out_flag_done, out_dato_leido, out_dato_valido, out_busy
    );
endinterface

// File: rtl/rtc_bus_transaction_driver.sv
// Runs one multiplexed address/data bus cycle on the parallel-bus RTC per command:
// address phase, recovery, data phase (write or read), recovery, done pulse, gap.
// Every output is a registered decode of the current state, so pins trail the
// state register by one cycle; phase lengths are unaffected by that lag.
module rtc_bus_transaction_driver #(
    parameter int unsigned T_FASE = 10,
    parameter int unsigned CW     = 8
) (
    input logic                          clk,
    input logic                          reset,
    rtc_bus_transaction_driver_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_REC,
        S_DATA_W,
        S_DATA_R,
        S_DATA_REC,
        S_DONE,
        S_GAP
    } state_t;

    localparam logic [CW-1:0] LAST = CW'(T_FASE - 1);

    state_t        state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic          phase_end;

    logic          cmd_w_r;
    logic [7:0]    cmd_addr;
    logic [7:0]    cmd_data;
    logic [7:0]    rd_hold;

    logic          cs_n_q, rd_n_q, wr_n_q, ad_q, oe_q, done_q, valido_q, busy_q;
    logic [7:0]    bus_dato_q, leido_q;
    logic          cs_n_d, rd_n_d, wr_n_d, ad_d, oe_d, done_d, valido_d, busy_d;
    logic [7:0]    bus_dato_d, leido_d;

    // State and phase-counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next state: timed phases advance when the counter reaches its last cycle
    always_comb begin
        state_next = state;
        cnt_next   = '0;
        phase_end  = (cnt == LAST);
        case (state)
            S_IDLE: begin
                if (bus.in_en_funcion_rtc) state_next = S_ADDR;
            end
            S_ADDR: begin
                if (phase_end) state_next = S_ADDR_REC;
                else           cnt_next   = cnt + CW'(1);
            end
            S_ADDR_REC: begin
                if (phase_end) state_next = cmd_w_r ? S_DATA_W : S_DATA_R;
                else           cnt_next   = cnt + CW'(1);
            end
            S_DATA_W: begin
                if (phase_end) state_next = S_DATA_REC;
                else           cnt_next   = cnt + CW'(1);
            end
            S_DATA_R: begin
                if (phase_end) state_next = S_DATA_REC;
                else           cnt_next   = cnt + CW'(1);
            end
            S_DATA_REC: begin
                if (phase_end) state_next = S_DONE;
                else           cnt_next   = cnt + CW'(1);
            end
            S_DONE:  state_next = S_GAP;
            S_GAP:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Command latch: accepted only from IDLE, so later input changes are ignored
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmd_w_r  <= 1'b0;
            cmd_addr <= '0;
            cmd_data <= '0;
        end else if (state == S_IDLE && bus.in_en_funcion_rtc) begin
            cmd_w_r  <= bus.in_funcion_w_r;
            cmd_addr <= bus.in_addr_ram_rtc;
            cmd_data <= bus.in_flag_inicio ? bus.in_dato_inicio : bus.in_dato_usuario;
        end
    end

    // Read holding register: sample the RTC on the last cycle of the read phase
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_hold <= '0;
        end else if (state == S_DATA_R && phase_end) begin
            rd_hold <= bus.in_bus_dato;
        end
    end

    // Output decode: next values of every pin from the current state
    always_comb begin
        cs_n_d     = 1'b1;
        rd_n_d     = 1'b1;
        wr_n_d     = 1'b1;
        ad_d       = 1'b0;
        oe_d       = 1'b0;
        bus_dato_d = '0;
        done_d     = 1'b0;
        valido_d   = 1'b0;
        busy_d     = (state != S_IDLE);
        leido_d    = leido_q;
        case (state)
            S_ADDR: begin
                cs_n_d     = 1'b0;
                wr_n_d     = 1'b0;
                oe_d       = 1'b1;
                bus_dato_d = cmd_addr;
            end
            S_ADDR_REC: begin
                oe_d       = 1'b1;
                bus_dato_d = cmd_addr;
            end
            S_DATA_W: begin
                cs_n_d     = 1'b0;
                wr_n_d     = 1'b0;
                ad_d       = 1'b1;
                oe_d       = 1'b1;
                bus_dato_d = cmd_data;
            end
            S_DATA_R: begin
                cs_n_d = 1'b0;
                rd_n_d = 1'b0;
                ad_d   = 1'b1;
            end
            S_DATA_REC: begin
                ad_d = 1'b1;
            end
            S_DONE: begin
                done_d = 1'b1;
                if (!cmd_w_r) begin
                    valido_d = 1'b1;
                    leido_d  = rd_hold;
                end
            end
            default: ;
        endcase
    end

    // Output register: reset releases every strobe immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cs_n_q     <= 1'b1;
            rd_n_q     <= 1'b1;
            wr_n_q     <= 1'b1;
            ad_q       <= 1'b0;
            oe_q       <= 1'b0;
            bus_dato_q <= '0;
            done_q     <= 1'b0;
            valido_q   <= 1'b0;
            busy_q     <= 1'b0;
            leido_q    <= '0;
        end else begin
            cs_n_q     <= cs_n_d;
            rd_n_q     <= rd_n_d;
            wr_n_q     <= wr_n_d;
            ad_q       <= ad_d;
            oe_q       <= oe_d;
            bus_dato_q <= bus_dato_d;
            done_q     <= done_d;
            valido_q   <= valido_d;
            busy_q     <= busy_d;
            leido_q    <= leido_d;
        end
    end

    assign bus.out_cs_n        = cs_n_q;
    assign bus.out_rd_n        = rd_n_q;
    assign bus.out_wr_n        = wr_n_q;
    assign bus.out_ad          = ad_q;
    assign bus.out_bus_oe      = oe_q;
    assign bus.out_bus_dato    = bus_dato_q;
    assign bus.out_flag_done   = done_q;
    assign bus.out_dato_valido = valido_q;
    assign bus.out_busy        = busy_q;
    assign bus.out_dato_leido  = leido_q;

endmodule

// File: tb/tb_rtc_bus_transaction_driver.sv
// Directed bench: DUT A with T_FASE = 2, DUT B with T_FASE = 10.
module tb_rtc_bus_transaction_driver;

    logic clk = 1'b0;
    logic reset;
    logic [7:0] rd_val_a, rd_val_b;

    int errors = 0;
    int checks = 0;

    rtc_bus_transaction_driver_if ifa();
    rtc_bus_transaction_driver_if ifb();

    rtc_bus_transaction_driver #(.T_FASE(2), .CW(8)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (ifa)
    );

    rtc_bus_transaction_driver #(.T_FASE(10), .CW(8)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (ifb)
    );

    always #5 clk = ~clk;

    // RTC model: presents read data only while the read strobe is low
    assign ifa.in_bus_dato = ifa.out_rd_n ? 8'hEE : rd_val_a;
    assign ifb.in_bus_dato = ifb.out_rd_n ? 8'hEE : rd_val_b;

    typedef struct packed {
        logic       cs;
        logic       wr;
        logic       rd;
        logic       ad;
        logic       oe;
        logic       done;
        logic       val;
        logic       busy;
        logic [7:0] d;
    } pins_t;

    typedef struct {
        bit         sel;
        bit         w_r;
        bit         flag;
        logic [7:0] addr;
        logic [7:0] ini;
        logic [7:0] usr;
        logic [7:0] bus_in;
        logic [7:0] exp_data;
        logic [7:0] exp_leido;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input bit sel, input logic en, input logic w_r, input logic flag,
                         input logic [7:0] addr, input logic [7:0] ini, input logic [7:0] usr);
        if (sel == 1'b0) begin
            ifa.in_en_funcion_rtc = en;
            ifa.in_funcion_w_r    = w_r;
            ifa.in_flag_inicio    = flag;
            ifa.in_addr_ram_rtc   = addr;
            ifa.in_dato_inicio    = ini;
            ifa.in_dato_usuario   = usr;
        end else begin
            ifb.in_en_funcion_rtc = en;
            ifb.in_funcion_w_r    = w_r;
            ifb.in_flag_inicio    = flag;
            ifb.in_addr_ram_rtc   = addr;
            ifb.in_dato_inicio    = ini;
            ifb.in_dato_usuario   = usr;
        end
    endtask

    // Bus value only matters while the driver owns the bus
    task automatic sample(input bit sel, output pins_t p);
        if (sel == 1'b0) begin
            p.cs = ifa.out_cs_n;   p.wr = ifa.out_wr_n;   p.rd = ifa.out_rd_n;
            p.ad = ifa.out_ad;     p.oe = ifa.out_bus_oe; p.done = ifa.out_flag_done;
            p.val = ifa.out_dato_valido; p.busy = ifa.out_busy;
            p.d = ifa.out_bus_oe ? ifa.out_bus_dato : 8'h00;
        end else begin
            p.cs = ifb.out_cs_n;   p.wr = ifb.out_wr_n;   p.rd = ifb.out_rd_n;
            p.ad = ifb.out_ad;     p.oe = ifb.out_bus_oe; p.done = ifb.out_flag_done;
            p.val = ifb.out_dato_valido; p.busy = ifb.out_busy;
            p.d = ifb.out_bus_oe ? ifb.out_bus_dato : 8'h00;
        end
    endtask

    // Expected pins k edges after the latch edge, from the phase timing alone
    function automatic pins_t exp_pins(input int k, input int t, input bit w,
                                       input logic [7:0] a, input logic [7:0] d);
        pins_t p;
        p.cs = 1'b1; p.wr = 1'b1; p.rd = 1'b1; p.ad = 1'b0; p.oe = 1'b0;
        p.done = 1'b0; p.val = 1'b0; p.busy = 1'b1; p.d = 8'h00;
        if (k <= t) begin
            p.cs = 1'b0; p.wr = 1'b0; p.oe = 1'b1; p.d = a;
        end else if (k <= 2 * t) begin
            p.oe = 1'b1; p.d = a;
        end else if (k <= 3 * t) begin
            p.cs = 1'b0; p.ad = 1'b1;
            if (w) begin
                p.wr = 1'b0; p.oe = 1'b1; p.d = d;
            end else begin
                p.rd = 1'b0;
            end
        end else if (k <= 4 * t) begin
            p.ad = 1'b1;
        end else begin
            p.done = 1'b1; p.val = !w;
        end
        return p;
    endfunction

    function automatic pins_t idle_pins();
        pins_t p;
        p.cs = 1'b1; p.wr = 1'b1; p.rd = 1'b1; p.ad = 1'b0; p.oe = 1'b0;
        p.done = 1'b0; p.val = 1'b0; p.busy = 1'b0; p.d = 8'h00;
        return p;
    endfunction

    task automatic run_txn(input int idx, input vec_t v);
        int    t;
        pins_t act, e;
        logic [7:0] leido;
        t = v.sel ? 10 : 2;
        @(negedge clk);
        if (v.sel) rd_val_b = v.bus_in; else rd_val_a = v.bus_in;
        drive(v.sel, 1'b1, v.w_r, v.flag, v.addr, v.ini, v.usr);
        @(posedge clk);
        @(negedge clk);
        drive(v.sel, 1'b0, !v.w_r, !v.flag, 8'h99, 8'h66, 8'h77);
        for (int k = 1; k <= 4 * t + 2; k++) begin
            @(posedge clk);
            #1;
            sample(v.sel, act);
            if (k <= 4 * t + 1) begin
                e = exp_pins(k, t, v.w_r, v.addr, v.exp_data);
                if (k == 4 * t + 1) act.ad = 1'b0;
                chk($sformatf("v%0d_pins_k%0d", idx, k), {16'h0, act}, {16'h0, e});
            end else begin
                chk($sformatf("v%0d_after_done", idx), {29'h0, act.done, act.val, act.cs},
                    32'h1);
            end
        end
        leido = v.sel ? ifb.out_dato_leido : ifa.out_dato_leido;
        chk($sformatf("v%0d_dato_leido", idx), {24'h0, leido}, {24'h0, v.exp_leido});
    endtask

    initial begin
        pins_t act;
        int    n_done, seen, cyc, last_start, extra;
        logic  prev_cs, cs_ok;

        tbl[0] = '{1'b0, 1'b1, 1'b0, 8'h21, 8'h00, 8'h45, 8'h00, 8'h45, 8'h00};
        tbl[1] = '{1'b0, 1'b0, 1'b0, 8'hF0, 8'h00, 8'h00, 8'h37, 8'h00, 8'h37};
        tbl[2] = '{1'b0, 1'b1, 1'b1, 8'h02, 8'h10, 8'hFF, 8'h00, 8'h10, 8'h37};
        tbl[3] = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h11, 8'h22, 8'hA5, 8'h00, 8'hA5};
        tbl[4] = '{1'b0, 1'b1, 1'b0, 8'hFF, 8'h55, 8'h00, 8'h00, 8'h00, 8'hA5};
        tbl[5] = '{1'b1, 1'b0, 1'b0, 8'h5C, 8'h00, 8'h00, 8'hC3, 8'h00, 8'hC3};
        tbl[6] = '{1'b1, 1'b1, 1'b1, 8'h81, 8'h3C, 8'hC0, 8'h00, 8'h3C, 8'hC3};

        reset    = 1'b1;
        rd_val_a = 8'h00;
        rd_val_b = 8'h00;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        sample(1'b0, act);
        chk("reset_pins_a", {16'h0, act}, {16'h0, idle_pins()});
        sample(1'b1, act);
        chk("reset_pins_b", {16'h0, act}, {16'h0, idle_pins()});
        chk("reset_leido_a", {24'h0, ifa.out_dato_leido}, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Reset during the address phase of a write
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 8'h21, 8'h00, 8'h45);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h21, 8'h00, 8'h45);
        @(posedge clk);
        #1;
        chk("midrst_pre_cs", {31'h0, ifa.out_cs_n}, 32'h0);
        #2;
        reset = 1'b1;
        #1;
        sample(1'b0, act);
        chk("midrst_release", {16'h0, act}, {16'h0, idle_pins()});
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        n_done = 0;
        cs_ok  = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (ifa.out_flag_done) n_done++;
            if (!ifa.out_cs_n || ifa.out_busy) cs_ok = 1'b0;
        end
        chk("midrst_no_done", n_done, 0);
        chk("midrst_stays_idle", {31'h0, cs_ok}, 32'h1);

        for (int i = 0; i < 7; i++) run_txn(i, tbl[i]);

        // Back-to-back commands from a counter-stepping FSM stub
        n_done     = 0;
        seen       = 0;
        cyc        = 0;
        last_start = 0;
        prev_cs    = 1'b1;
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 8'h40, 8'h00, 8'h80);
        while (n_done < 12 && cyc < 400) begin
            @(posedge clk);
            #1;
            cyc++;
            if (!ifa.out_cs_n && !ifa.out_ad && prev_cs) begin
                chk($sformatf("b2b_addr%0d", seen), {24'h0, ifa.out_bus_dato},
                    32'h40 + 32'(seen));
                if (seen > 0) chk($sformatf("b2b_spacing%0d", seen), cyc - last_start, 11);
                last_start = cyc;
                seen++;
            end
            prev_cs = ifa.out_cs_n;
            if (ifa.out_flag_done) begin
                n_done++;
                drive(1'b0, (n_done < 12), 1'b1, 1'b0, 8'(8'h40 + n_done), 8'h00,
                      8'(8'h80 + n_done));
            end
        end
        chk("b2b_done_count", n_done, 12);
        extra = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk);
            #1;
            if (ifa.out_flag_done) extra++;
            if (!ifa.out_cs_n && !ifa.out_ad && prev_cs) seen++;
            prev_cs = ifa.out_cs_n;
        end
        chk("b2b_no_extra_done", extra, 0);
        chk("b2b_cmds_issued", seen, 12);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
